// File: rtl/calc_pkg.sv
// Shared types and constants for the UART calculator command parser:
// FSM states, operator/error codes and the ASCII bytes the grammar uses.
package calc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SP1,
        ST_MODE,
        ST_SP2,
        ST_A_FIRST,
        ST_A_DIG,
        ST_B_FIRST,
        ST_B_DIG,
        ST_DONE
    } state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [2:0] ERR_NONE            = 3'd0;
    localparam logic [2:0] ERR_BAD_CHAR        = 3'd1;
    localparam logic [2:0] ERR_TOO_MANY_DIGITS = 3'd2;
    localparam logic [2:0] ERR_NO_DIGITS       = 3'd3;
    localparam logic [2:0] ERR_OVERRUN         = 3'd4;

    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_I     = 8'h49;
    localparam logic [7:0] ASCII_U     = 8'h55;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

endpackage

// File: rtl/calc_char_decode.sv
// Combinational byte classifier: digit value, operator code, '=' and '-'.
module calc_char_decode
    import calc_pkg::*;
(
    input  logic [7:0] data_i,
    output logic       is_digit_o,
    output logic [3:0] digit_o,
    output logic       is_op_o,
    output logic [1:0] op_o,
    output logic       is_eq_o,
    output logic       is_minus_o
);

    always_comb begin
        is_digit_o = (data_i >= ASCII_ZERO) && (data_i <= ASCII_ZERO + 8'd9);
        // ASCII '0'..'9' carry the digit value in their low nibble.
        digit_o    = data_i[3:0];
        is_eq_o    = (data_i == ASCII_EQ);
        is_minus_o = (data_i == ASCII_MINUS);
        is_op_o    = 1'b1;
        op_o       = OP_ADD;
        case (data_i)
            ASCII_PLUS:  op_o = OP_ADD;
            ASCII_MINUS: op_o = OP_SUB;
            ASCII_STAR:  op_o = OP_MUL;
            ASCII_SLASH: op_o = OP_DIV;
            default:     is_op_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/calc_cmd_parser.sv
// Parses "I <U|S> <A><op><B>=" frames into binary operands for the ALU.
// out_valid/out_ready: a command is held stable until out_valid & out_ready on a rising edge.
module calc_cmd_parser
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OP_W   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_a,
    output logic [OP_W-1:0] out_b,
    output logic [1:0]      out_op,
    output logic            out_signed,
    output logic            err_valid,
    output logic [2:0]      err_code
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e          state_q, state_d;
    logic [OP_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic [OP_W-1:0] a_q, a_d;
    logic [OP_W-1:0] b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic            signed_q, signed_d;
    logic            err_valid_q, err_valid_d;
    logic [2:0]      err_code_q, err_code_d;

    logic            is_digit, is_op, is_eq, is_minus;
    logic [3:0]      digit;
    logic [1:0]      op_code;
    logic [OP_W-1:0] acc_mac;
    logic [2:0]      err;

    calc_char_decode u_decode (
        .data_i     (in_data),
        .is_digit_o (is_digit),
        .digit_o    (digit),
        .is_op_o    (is_op),
        .op_o       (op_code),
        .is_eq_o    (is_eq),
        .is_minus_o (is_minus)
    );

    // acc*10 + d without a multiplier.
    assign acc_mac = (acc_q << 3) + (acc_q << 1) + OP_W'(digit);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        signed_d    = signed_q;
        err_valid_d = 1'b0;
        err_code_d  = ERR_NONE;
        err         = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_data == ASCII_I) state_d = ST_SP1;
            end
            ST_SP1: begin
                if (in_valid) begin
                    if (in_data == ASCII_SP) state_d = ST_MODE;
                    else                     err = ERR_BAD_CHAR;
                end
            end
            ST_MODE: begin
                if (in_valid) begin
                    if (in_data == ASCII_U) begin
                        signed_d = 1'b0;
                        state_d  = ST_SP2;
                    end else if (in_data == ASCII_S) begin
                        signed_d = 1'b1;
                        state_d  = ST_SP2;
                    end else begin
                        err = ERR_BAD_CHAR;
                    end
                end
            end
            ST_SP2: begin
                if (in_valid) begin
                    if (in_data == ASCII_SP) begin
                        state_d = ST_A_FIRST;
                        acc_d   = '0;
                        cnt_d   = '0;
                        neg_a_d = 1'b0;
                    end else begin
                        err = ERR_BAD_CHAR;
                    end
                end
            end
            ST_A_FIRST, ST_B_FIRST: begin
                if (in_valid) begin
                    if (is_digit) begin
                        acc_d   = OP_W'(digit);
                        cnt_d   = CNT_ONE;
                        state_d = (state_q == ST_A_FIRST) ? ST_A_DIG : ST_B_DIG;
                    end else if (is_minus) begin
                        // A sign is only legal once, and only in S mode.
                        if (!signed_q) err = ERR_BAD_CHAR;
                        else if (state_q == ST_A_FIRST) begin
                            if (neg_a_q) err = ERR_BAD_CHAR;
                            else         neg_a_d = 1'b1;
                        end else begin
                            if (neg_b_q) err = ERR_BAD_CHAR;
                            else         neg_b_d = 1'b1;
                        end
                    end else if (is_op || is_eq) begin
                        err = ERR_NO_DIGITS;
                    end else begin
                        err = ERR_BAD_CHAR;
                    end
                end
            end
            ST_A_DIG, ST_B_DIG: begin
                if (in_valid) begin
                    if (is_digit) begin
                        if (cnt_q == CNT_MAX) err = ERR_TOO_MANY_DIGITS;
                        else begin
                            acc_d = acc_mac;
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (state_q == ST_A_DIG && is_op) begin
                        a_d     = neg_a_q ? (~acc_q + OP_W'(1)) : acc_q;
                        op_d    = op_code;
                        state_d = ST_B_FIRST;
                        acc_d   = '0;
                        cnt_d   = '0;
                        neg_b_d = 1'b0;
                    end else if (state_q == ST_B_DIG && is_eq) begin
                        b_d     = neg_b_q ? (~acc_q + OP_W'(1)) : acc_q;
                        state_d = ST_DONE;
                    end else begin
                        err = ERR_BAD_CHAR;
                    end
                end
            end
            ST_DONE: begin
                // With out_ready high the incoming byte is treated as in IDLE.
                if (out_ready) begin
                    state_d = (in_valid && in_data == ASCII_I) ? ST_SP1 : ST_IDLE;
                end else if (in_valid) begin
                    err = ERR_OVERRUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (err != ERR_NONE) begin
            err_valid_d = 1'b1;
            err_code_d  = err;
            if (err != ERR_OVERRUN) begin
                state_d = (in_data == ASCII_I) ? ST_SP1 : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            signed_q    <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            signed_q    <= signed_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign out_valid  = (state_q == ST_DONE);
    assign out_a      = a_q;
    assign out_b      = b_q;
    assign out_op     = op_q;
    assign out_signed = signed_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_calc_cmd_parser.sv
// Directed bench for calc_cmd_parser: frames are sent as ASCII strings on
// back-to-back in_valid cycles and outputs are checked #1 after the edge.
module tb_calc_cmd_parser;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [1:0]  out_op;
    logic        out_signed;
    logic        err_valid;
    logic [2:0]  err_code;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int err_cnt = 0;

    calc_cmd_parser #(.DIGITS(4), .OP_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_op     (out_op),
        .out_signed (out_signed),
        .err_valid  (err_valid),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitors: completed handshakes and error pulses.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
        if (!rst && err_valid) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic check_cmd(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [1:0] op, input logic sgn);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".a"}, {16'd0, out_a}, {16'd0, a});
        check({tag, ".b"}, {16'd0, out_b}, {16'd0, b});
        check({tag, ".op"}, {30'd0, out_op}, {30'd0, op});
        check({tag, ".signed"}, {31'd0, out_signed}, {31'd0, sgn});
    endtask

    task automatic check_err(input string tag, input logic [2:0] code);
        check({tag, ".err_valid"}, {31'd0, err_valid}, 32'd1);
        check({tag, ".err_code"}, {29'd0, err_code}, {29'd0, code});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.a", {16'd0, out_a}, 32'd0);
        check("rst.b", {16'd0, out_b}, 32'd0);
        check("rst.op", {30'd0, out_op}, 32'd0);
        check("rst.signed", {31'd0, out_signed}, 32'd0);
        check("rst.err_valid", {31'd0, err_valid}, 32'd0);
        check("rst.err_code", {29'd0, err_code}, 32'd0);
        rst = 1'b0;
        tick();

        send_str("I U 0004+0008=");
        check_cmd("f1", 16'd4, 16'd8, 2'd0, 1'b0);
        tick();
        check("f1.valid_fall", {31'd0, out_valid}, 32'd0);
        check("f1.hs", hs_cnt, 32'd1);

        // Second frame starts in DONE while out_ready is high.
        send_str("I S 1234+5678=");
        check_cmd("f2a", 16'h04D2, 16'h162E, 2'd0, 1'b1);
        send_str("I S 0004-0002=");
        check_cmd("f2b", 16'd4, 16'd2, 2'd1, 1'b1);
        tick();

        send_str("I S -12*-3=");
        check_cmd("f3", 16'hFFF4, 16'hFFFD, 2'd2, 1'b1);
        tick();
        check("f3.hs", hs_cnt, 32'd4);
        check("f3.err_cnt", err_cnt, 32'd0);

        send_str("I U 1234");
        send_byte("5");
        check_err("f4.too_many", 3'd2);
        send_str("+1=");
        check("f4.no_valid", {31'd0, out_valid}, 32'd0);
        check("f4.err_cnt", err_cnt, 32'd1);
        send_str("I U 7/2=");
        check_cmd("f4b", 16'd7, 16'd2, 2'd3, 1'b0);
        tick();

        send_str("I U ");
        send_byte("-");
        check_err("f5.minus_u", 3'd1);
        send_str("5+1=");
        check("f5.no_valid", {31'd0, out_valid}, 32'd0);
        send_str("I U 1+1=");
        check_cmd("f5b", 16'd1, 16'd1, 2'd0, 1'b0);
        tick();

        send_str("I U ");
        send_byte("+");
        check_err("f6.no_digits", 3'd3);
        send_str("I U 1+1=");
        check_cmd("f6b", 16'd1, 16'd1, 2'd0, 1'b0);
        tick();

        // An offending 'I' restarts the frame directly.
        send_str("I U 1");
        send_byte("I");
        check_err("f7.resync_i", 3'd1);
        send_str(" U 2+3=");
        check_cmd("f7b", 16'd2, 16'd3, 2'd0, 1'b0);
        tick();

        send_str("I S 5-");
        send_byte("-");
        check("f8.sub_neg_ok", {31'd0, err_valid}, 32'd0);
        send_byte("-");
        check_err("f8.double_minus", 3'd1);

        send_str("I U 9999*9999=");
        check_cmd("f9", 16'h270F, 16'h270F, 2'd2, 1'b0);
        tick();
        check("f9.err_cnt", err_cnt, 32'd5);

        out_ready = 1'b0;
        send_str("I U 3-1=");
        check_cmd("bp", 16'd3, 16'd1, 2'd1, 1'b0);
        tick();
        check("bp.hold", {31'd0, out_valid}, 32'd1);
        send_byte("X");
        check_err("bp.overrun", 3'd4);
        check_cmd("bp.kept", 16'd3, 16'd1, 2'd1, 1'b0);
        out_ready = 1'b1;
        send_byte("I");
        check("bp.no_err", {31'd0, err_valid}, 32'd0);
        check("bp.released", {31'd0, out_valid}, 32'd0);
        send_str(" U 5+6=");
        check_cmd("bp.next", 16'd5, 16'd6, 2'd0, 1'b0);
        tick();
        check("bp.hs", hs_cnt, 32'd11);
        check("bp.err_cnt", err_cnt, 32'd6);

        send_str("I S -7");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst.a", {16'd0, out_a}, 32'd0);
        check("mrst.b", {16'd0, out_b}, 32'd0);
        check("mrst.op", {30'd0, out_op}, 32'd0);
        check("mrst.signed", {31'd0, out_signed}, 32'd0);
        check("mrst.err_valid", {31'd0, err_valid}, 32'd0);
        send_str("+2=");
        check("mrst.idle", {31'd0, out_valid}, 32'd0);
        check("mrst.no_err", {31'd0, err_valid}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/calc_cmd_parser.md
# calc_cmd_parser

Parametrised ASCII command parser between the UART receiver and the calculator ALU in the UART calculator. It consumes the received byte stream, validates frames of the form `I <U|S> <A><op><B>=`, converts both decimal operands to binary, and presents one command per frame to the ALU over a valid/ready handshake. Relative to the fixed 4-digit parsing it replaces, it adds:

- variable-length operands of 1..DIGITS digits;
- signed operands with a leading `-` in S mode;
- error reporting;
- output back-pressure.

## Interface

Parameters:

- `DIGITS`, 4: maximum decimal digits per operand.
- `OP_W`, 16: operand width in bits. Must satisfy 2^(OP_W-1) > 10^DIGITS - 1.

Ports:

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: one received byte is presented this cycle.
- `in_data` in 8: received ASCII byte.
- `out_valid` out 1: a parsed command is held on the outputs.
- `out_ready` in 1: the ALU accepts the command.
- `out_a` out OP_W: operand A, two's complement.
- `out_b` out OP_W: operand B, two's complement.
- `out_op` out 2: operator code. 0 = `+`, 1 = `-`, 2 = `*`, 3 = `/`.
- `out_signed` out 1: 1 for `S`, 0 for `U`.
- `err_valid` out 1: one-cycle error pulse.
- `err_code` out 3: 1 = BAD_CHAR, 2 = TOO_MANY_DIGITS, 3 = NO_DIGITS, 4 = OVERRUN.

## Operation

State machine. Each state advances on `in_valid` with the byte shown.

- IDLE: `I` (0x49) goes to SP1. Any other byte is ignored silently.
- SP1: 0x20 goes to MODE.
- MODE: `U` (0x55) or `S` (0x53) latches `out_signed` and goes to SP2.
- SP2: 0x20 goes to A_FIRST.
- A_FIRST: a digit loads acc and goes to A_DIG. `-` is accepted only in S mode; it sets neg_a and stays in A_FIRST.
- A_DIG:
  - a digit accumulates;
  - an operator byte (0x2B, 0x2D, 0x2A, 0x2F) stores A, latches `out_op` and goes to B_FIRST.
- B_FIRST: same as A_FIRST, using neg_b.
- B_DIG: a digit accumulates. `=` (0x3D) stores B and goes to DONE.
- DONE: `out_valid`=1. `out_ready` returns the machine to IDLE.

Accumulation and conversion:

- acc_next = acc*10 + (in_data - 0x30), computed as (acc<<3)+(acc<<1)+d.
- The digit counter is cleared at each operand start.
- The operand value is the magnitude, negated (two's complement) when the neg flag is set.
- In U mode, magnitude < 2^OP_W.

Error rules. Every error pulses `err_valid` with its code and forces the parser out of the current frame.

- BAD_CHAR: any unexpected byte in SP1..B_DIG. This includes `-` in U mode and a second `-` in one operand.
- TOO_MANY_DIGITS: digit number DIGITS+1 of either operand.
- NO_DIGITS: an operator or `=` arrives in A_FIRST or B_FIRST.
- OVERRUN: any byte arriving in DONE while `out_ready`=0. The held command is kept and the machine stays in DONE. The byte is dropped.
- Resync: if the offending byte is `I`, the next state is SP1. Otherwise it is IDLE.

## Timing

- One byte is processed per `in_valid` cycle. Back-to-back `in_valid` is legal.
- `out_valid` rises on the cycle after `=` is accepted.
- `out_a`, `out_b`, `out_op` and `out_signed` are stable while `out_valid`=1.
- `out_valid` falls the cycle after `out_valid & out_ready`.
- If `in_valid` and `out_ready` are both high in DONE, the byte is handled as in IDLE. No OVERRUN is reported.
- `err_valid` is high exactly on the cycle after the offending byte.
- Reset values: every output is 0, the state is IDLE, and acc, the digit counter and the neg flags are 0.
- `rst` mid-frame or in DONE discards everything. No error is reported.

## Structure

- Package `calc_pkg` holds:
  - the state enum;
  - op codes and err codes;
  - ASCII constants (0x20, 0x49, 0x55, 0x53, 0x2B, 0x2D, 0x2A, 0x2F, 0x3D, 0x30).
- Sub-module `calc_char_decode` is purely combinational. It maps a byte to `is_digit`, `digit[3:0]`, `is_op`, `op[1:0]`, `is_eq`, `is_minus`.
- The top level holds the FSM, the accumulator, the digit counter and the output registers.

## Test plan

Each frame is driven on back-to-back `in_valid` cycles; `out_ready`=1 unless stated.

- Frame `I U 0004+0008=`: `out_a`=4, `out_b`=8, `out_op`=0, `out_signed`=0, and one `out_valid` handshake.
- Frame `I S 1234+5678=` followed by `I S 0004-0002=`: first 0x04D2 and 0x162E with op 0; then 4 and 2 with op 1 and `out_signed`=1.
- Frame `I S -12*-3=`: `out_a`=16'hFFF4, `out_b`=16'hFFFD, `out_op`=2.
- Frame `I U 12345+1=`: err 2 on the fifth digit and no `out_valid`. A following `I U 7/2=` then gives 7, 2, op 3.
- Two error frames:
  - `I U -5+1=` gives err 1 on `-`;
  - `I U +` gives err 3.
  - After each, an `I` resyncs and `I U 1+1=` parses correctly.
- Back-pressure: hold `out_ready`=0 after a valid frame and send `X`. Expect err 4 with the outputs unchanged. Then raise `out_ready` together with `in_valid`=`I`: no error and the next frame parses. Finally assert `rst` mid-frame: all outputs return to 0.
